// File: rtl/ahb_lsu_master_if.sv
// Signal bundle between the core load/store unit, the AHB-Lite initiator and the data bus.
// The master modport is the initiator's view; slave is the view of the core/bus side.
interface ahb_lsu_master_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;

    logic                  rsp_valid;
    logic [31:0]           rsp_rdata;
    logic                  rsp_error;
    logic                  rsp_misalign;

    logic [ADDR_WIDTH-1:0] haddr;
    logic [1:0]            htrans;
    logic                  hwrite;
    logic [2:0]            hsize;
    logic [2:0]            hburst;
    logic [3:0]            hprot;
    logic                  hmastlock;
    logic [31:0]           hwdata;
    logic [31:0]           hrdata;
    logic                  hready;
    logic                  hresp;

    modport master (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  hrdata, hready, hresp,
        output req_ready, rsp_valid, rsp_rdata, rsp_error, rsp_misalign,
        output haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock, hwdata
    );

    modport slave (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output hrdata, hready, hresp,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error, rsp_misalign,
        input  haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock, hwdata
    );
endinterface

// File: rtl/ahb_lsu_master.sv
// AHB-Lite initiator converting LSU request/response handshakes into pipelined single
// transfers, with byte-lane alignment, load extension, wait-state and error handling.
module ahb_lsu_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input logic              HCLK,
    input logic              HRESETn,
    ahb_lsu_master_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ERR2 = 2'd2
    } state_t;

    state_t state, state_next;

    logic                  aligned;
    logic                  req_ready_int;
    logic                  accept;
    logic                  err_first;
    logic                  dp_done;
    logic                  issue;
    logic [ADDR_WIDTH-1:0] addr_out;

    logic                  dp_valid;
    logic                  dp_write;
    logic [1:0]            dp_size;
    logic                  dp_unsigned;
    logic [1:0]            dp_addr;
    logic                  dp_misalign;
    logic [DATA_WIDTH-1:0] hwdata_q;

    logic [31:0]           lane;
    logic [31:0]           load_ext;

    always_comb begin
        aligned = 1'b0;
        case (bus.req_size)
            2'd0:    aligned = 1'b1;
            2'd1:    aligned = ~bus.req_addr[0];
            2'd2:    aligned = (bus.req_addr[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
    end

    // First ERROR cycle: the address presented now must be cancelled, not issued.
    assign err_first     = (state == ST_DATA) & ~dp_misalign & bus.hresp & ~bus.hready;
    assign req_ready_int = HRESETn & bus.hready & (state != ST_ERR2);
    assign accept        = bus.req_valid & req_ready_int;
    assign dp_done       = (state == ST_DATA) & dp_valid & (bus.hready | dp_misalign);
    assign issue         = HRESETn & bus.req_valid & aligned & (state != ST_ERR2) & ~err_first;
    assign addr_out      = issue ? bus.req_addr : '0;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) state_next = ST_DATA;
            end
            ST_DATA: begin
                if (err_first)    state_next = ST_ERR2;
                else if (accept)  state_next = ST_DATA;
                else if (dp_done) state_next = ST_IDLE;
            end
            ST_ERR2: begin
                if (bus.hready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_valid    <= 1'b0;
            dp_write    <= 1'b0;
            dp_size     <= 2'd0;
            dp_unsigned <= 1'b0;
            dp_addr     <= 2'd0;
            dp_misalign <= 1'b0;
        end else if (accept) begin
            dp_valid    <= 1'b1;
            dp_write    <= bus.req_write;
            dp_size     <= bus.req_size;
            dp_unsigned <= bus.req_unsigned;
            dp_addr     <= bus.req_addr[1:0];
            dp_misalign <= ~aligned;
        end else if (dp_done || ((state == ST_ERR2) && bus.hready)) begin
            dp_valid <= 1'b0;
        end
    end

    // Store data is replicated across all lanes so the slave picks the right bytes by address.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hwdata_q <= '0;
        end else if (accept) begin
            case (bus.req_size)
                2'd0:    hwdata_q <= {4{bus.req_wdata[7:0]}};
                2'd1:    hwdata_q <= {2{bus.req_wdata[15:0]}};
                default: hwdata_q <= bus.req_wdata;
            endcase
        end
    end

    always_comb begin
        lane     = bus.hrdata >> {dp_addr, 3'b000};
        load_ext = lane;
        case (dp_size)
            2'd0:    load_ext = dp_unsigned ? {24'd0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
            2'd1:    load_ext = dp_unsigned ? {16'd0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
            default: load_ext = lane;
        endcase
    end

    always_comb begin
        bus.req_ready    = req_ready_int;
        bus.htrans       = issue ? 2'b10 : 2'b00;
        bus.haddr        = addr_out;
        bus.hwrite       = issue & bus.req_write;
        bus.hsize        = issue ? {1'b0, bus.req_size} : 3'b000;
        bus.hburst       = 3'b000;
        bus.hprot        = 4'b0011;
        bus.hmastlock    = 1'b0;
        bus.hwdata       = hwdata_q;
        bus.rsp_valid    = 1'b0;
        bus.rsp_rdata    = 32'd0;
        bus.rsp_error    = 1'b0;
        bus.rsp_misalign = 1'b0;
        case (state)
            ST_DATA: begin
                bus.rsp_valid    = dp_done;
                bus.rsp_misalign = dp_valid & dp_misalign;
                if (dp_done && !dp_misalign && !dp_write) bus.rsp_rdata = load_ext;
            end
            ST_ERR2: begin
                bus.rsp_valid = bus.hready;
                bus.rsp_error = bus.hready;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ahb_lsu_master.sv
// Directed self-checking bench for ahb_lsu_master: loads, stores, pipelining, errors,
// misalignment and asynchronous reset.
module tb_ahb_lsu_master;

    logic HCLK;
    logic HRESETn;
    int   pass_count  = 0;
    int   check_count = 0;

    ahb_lsu_master_if #(.ADDR_WIDTH(32)) bus ();

    ahb_lsu_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    task drive_req(input logic w, input logic [1:0] sz, input logic uns,
                   input logic [31:0] a, input logic [31:0] wd);
        bus.req_valid    = 1'b1;
        bus.req_write    = w;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
    endtask

    task drop_req();
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_size  = 2'd0;
        bus.req_addr  = 32'd0;
        bus.req_wdata = 32'd0;
    endtask

    // Each step: move to the falling edge, apply inputs, then sample just after settling.
    task step();
        @(negedge HCLK);
    endtask

    task test_reset();
        HRESETn = 1'b0;
        drop_req();
        bus.req_unsigned = 1'b0;
        bus.hrdata = 32'd0;
        bus.hready = 1'b1;
        bus.hresp  = 1'b0;
        #12;
        check_count++; if (bus.req_ready !== 1'b0) $display("[TB] FAIL reset_req_ready: got %b want 0", bus.req_ready); else pass_count++;
        check_count++; if (bus.htrans !== 2'b00) $display("[TB] FAIL reset_htrans: got %h want 0", bus.htrans); else pass_count++;
        check_count++; if (bus.rsp_valid !== 1'b0) $display("[TB] FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); else pass_count++;
        check_count++; if (bus.hwdata !== 32'd0) $display("[TB] FAIL reset_hwdata: got %h want 0", bus.hwdata); else pass_count++;
        check_count++; if ({bus.hburst, bus.hprot, bus.hmastlock} !== 8'b000_0011_0) $display("[TB] FAIL const_ctrl: got %b want 00000110", {bus.hburst, bus.hprot, bus.hmastlock}); else pass_count++;
        step();
        HRESETn = 1'b1;
        #1;
        check_count++; if (bus.req_ready !== 1'b1) $display("[TB] FAIL post_reset_ready: got %b want 1", bus.req_ready); else pass_count++;
    endtask

    task test_word_load();
        step(); drive_req(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'd0); #1;
        check_count++; if (bus.htrans !== 2'b10) $display("[TB] FAIL wl_htrans: got %h want 2", bus.htrans); else pass_count++;
        check_count++; if (bus.hsize !== 3'd2) $display("[TB] FAIL wl_hsize: got %h want 2", bus.hsize); else pass_count++;
        check_count++; if (bus.haddr !== 32'h10) $display("[TB] FAIL wl_haddr: got %h want 10", bus.haddr); else pass_count++;
        check_count++; if (bus.rsp_valid !== 1'b0) $display("[TB] FAIL wl_early_rsp: got %b want 0", bus.rsp_valid); else pass_count++;
        step(); drop_req(); bus.hrdata = 32'hDEAD_BEEF; #1;
        check_count++; if (bus.rsp_valid !== 1'b1) $display("[TB] FAIL wl_rsp_valid: got %b want 1", bus.rsp_valid); else pass_count++;
        check_count++; if (bus.rsp_rdata !== 32'hDEAD_BEEF) $display("[TB] FAIL wl_rdata: got %h want deadbeef", bus.rsp_rdata); else pass_count++;
        check_count++; if (bus.htrans !== 2'b00) $display("[TB] FAIL wl_idle_htrans: got %h want 0", bus.htrans); else pass_count++;
        step(); #1;
        check_count++; if (bus.rsp_valid !== 1'b0) $display("[TB] FAIL wl_rsp_drop: got %b want 0", bus.rsp_valid); else pass_count++;
    endtask

    task test_byte_loads();
        step(); drive_req(1'b0, 2'd0, 1'b0, 32'h0000_0013, 32'd0); #1;
        check_count++; if (bus.hsize !== 3'd0) $display("[TB] FAIL bl_hsize: got %h want 0", bus.hsize); else pass_count++;
        step(); drive_req(1'b0, 2'd0, 1'b1, 32'h0000_0013, 32'd0); bus.hrdata = 32'h8012_3456; #1;
        check_count++; if (bus.rsp_rdata !== 32'hFFFF_FF80) $display("[TB] FAIL bl_signed: got %h want ffffff80", bus.rsp_rdata); else pass_count++;
        step(); drop_req(); bus.hrdata = 32'h80AB_CDEF; #1;
        check_count++; if (bus.rsp_rdata !== 32'h0000_0080) $display("[TB] FAIL bl_unsigned: got %h want 00000080", bus.rsp_rdata); else pass_count++;
        step(); drive_req(1'b0, 2'd1, 1'b0, 32'h0000_0002, 32'd0); #1;
        step(); drop_req(); bus.hrdata = 32'h9ABC_1234; #1;
        check_count++; if (bus.rsp_rdata !== 32'hFFFF_9ABC) $display("[TB] FAIL hl_signed: got %h want ffff9abc", bus.rsp_rdata); else pass_count++;
    endtask

    task test_half_store();
        step(); drive_req(1'b1, 2'd1, 1'b0, 32'h0000_0002, 32'h0000_1234); #1;
        check_count++; if (bus.hsize !== 3'd1) $display("[TB] FAIL hs_hsize: got %h want 1", bus.hsize); else pass_count++;
        check_count++; if (bus.hwrite !== 1'b1) $display("[TB] FAIL hs_hwrite: got %b want 1", bus.hwrite); else pass_count++;
        step(); drop_req(); bus.hready = 1'b0; #1;
        check_count++; if (bus.hwdata !== 32'h1234_1234) $display("[TB] FAIL hs_hwdata_w1: got %h want 12341234", bus.hwdata); else pass_count++;
        check_count++; if (bus.rsp_valid !== 1'b0) $display("[TB] FAIL hs_rsp_w1: got %b want 0", bus.rsp_valid); else pass_count++;
        check_count++; if (bus.req_ready !== 1'b0) $display("[TB] FAIL hs_ready_w1: got %b want 0", bus.req_ready); else pass_count++;
        step(); #1;
        check_count++; if (bus.hwdata !== 32'h1234_1234) $display("[TB] FAIL hs_hwdata_w2: got %h want 12341234", bus.hwdata); else pass_count++;
        check_count++; if (bus.rsp_valid !== 1'b0) $display("[TB] FAIL hs_rsp_w2: got %b want 0", bus.rsp_valid); else pass_count++;
        step(); bus.hready = 1'b1; #1;
        check_count++; if (bus.rsp_valid !== 1'b1) $display("[TB] FAIL hs_rsp_done: got %b want 1", bus.rsp_valid); else pass_count++;
        check_count++; if (bus.rsp_rdata !== 32'd0) $display("[TB] FAIL hs_rdata_zero: got %h want 0", bus.rsp_rdata); else pass_count++;
        check_count++; if (bus.hwdata !== 32'h1234_1234) $display("[TB] FAIL hs_hwdata_done: got %h want 12341234", bus.hwdata); else pass_count++;
        step(); #1;
        check_count++; if (bus.rsp_valid !== 1'b0) $display("[TB] FAIL hs_rsp_after: got %b want 0", bus.rsp_valid); else pass_count++;
    endtask

    task test_back_to_back();
        step(); drive_req(1'b0, 2'd2, 1'b0, 32'h0000_0000, 32'd0); #1;
        check_count++; if ({bus.htrans, bus.haddr} !== {2'b10, 32'h0}) $display("[TB] FAIL b2b_a0: got %h/%h want 2/0", bus.htrans, bus.haddr); else pass_count++;
        step(); drive_req(1'b0, 2'd2, 1'b0, 32'h0000_0004, 32'd0); bus.hrdata = 32'h1111_1111; #1;
        check_count++; if ({bus.htrans, bus.haddr} !== {2'b10, 32'h4}) $display("[TB] FAIL b2b_a1: got %h/%h want 2/4", bus.htrans, bus.haddr); else pass_count++;
        check_count++; if ({bus.rsp_valid, bus.rsp_rdata} !== {1'b1, 32'h1111_1111}) $display("[TB] FAIL b2b_r0: got %b/%h want 1/11111111", bus.rsp_valid, bus.rsp_rdata); else pass_count++;
        step(); drive_req(1'b0, 2'd2, 1'b0, 32'h0000_0008, 32'd0); bus.hrdata = 32'h2222_2222; #1;
        check_count++; if ({bus.htrans, bus.haddr} !== {2'b10, 32'h8}) $display("[TB] FAIL b2b_a2: got %h/%h want 2/8", bus.htrans, bus.haddr); else pass_count++;
        check_count++; if ({bus.rsp_valid, bus.rsp_rdata} !== {1'b1, 32'h2222_2222}) $display("[TB] FAIL b2b_r1: got %b/%h want 1/22222222", bus.rsp_valid, bus.rsp_rdata); else pass_count++;
        step(); drop_req(); bus.hrdata = 32'h3333_3333; #1;
        check_count++; if ({bus.rsp_valid, bus.rsp_rdata} !== {1'b1, 32'h3333_3333}) $display("[TB] FAIL b2b_r2: got %b/%h want 1/33333333", bus.rsp_valid, bus.rsp_rdata); else pass_count++;
        step(); #1;
        check_count++; if (bus.rsp_valid !== 1'b0) $display("[TB] FAIL b2b_end: got %b want 0", bus.rsp_valid); else pass_count++;
    endtask

    task test_error();
        step(); drive_req(1'b0, 2'd2, 1'b0, 32'h0000_0020, 32'd0); #1;
        check_count++; if (bus.req_ready !== 1'b1) $display("[TB] FAIL err_accept_a: got %b want 1", bus.req_ready); else pass_count++;
        step(); drive_req(1'b0, 2'd2, 1'b0, 32'h0000_0024, 32'd0); bus.hresp = 1'b1; bus.hready = 1'b0; #1;
        check_count++; if (bus.htrans !== 2'b00) $display("[TB] FAIL err1_htrans: got %h want 0", bus.htrans); else pass_count++;
        check_count++; if (bus.req_ready !== 1'b0) $display("[TB] FAIL err1_ready: got %b want 0", bus.req_ready); else pass_count++;
        check_count++; if (bus.rsp_valid !== 1'b0) $display("[TB] FAIL err1_rsp: got %b want 0", bus.rsp_valid); else pass_count++;
        step(); bus.hready = 1'b1; #1;
        check_count++; if ({bus.rsp_valid, bus.rsp_error} !== 2'b11) $display("[TB] FAIL err2_rsp: got %b want 11", {bus.rsp_valid, bus.rsp_error}); else pass_count++;
        check_count++; if ({bus.req_ready, bus.htrans} !== 3'b000) $display("[TB] FAIL err2_block: got %b want 000", {bus.req_ready, bus.htrans}); else pass_count++;
        step(); bus.hresp = 1'b0; #1;
        check_count++; if ({bus.htrans, bus.haddr, bus.req_ready} !== {2'b10, 32'h24, 1'b1}) $display("[TB] FAIL err_retry_issue: got %h/%h/%b want 2/24/1", bus.htrans, bus.haddr, bus.req_ready); else pass_count++;
        check_count++; if (bus.rsp_valid !== 1'b0) $display("[TB] FAIL err_idle_rsp: got %b want 0", bus.rsp_valid); else pass_count++;
        step(); drop_req(); bus.hrdata = 32'hCAFE_F00D; #1;
        check_count++; if ({bus.rsp_valid, bus.rsp_error, bus.rsp_rdata} !== {2'b10, 32'hCAFE_F00D}) $display("[TB] FAIL err_retry_rsp: got %b/%b/%h want 1/0/cafef00d", bus.rsp_valid, bus.rsp_error, bus.rsp_rdata); else pass_count++;
        step(); #1;
    endtask

    task test_misalign();
        step(); drive_req(1'b0, 2'd2, 1'b0, 32'h0000_0006, 32'd0); #1;
        check_count++; if (bus.htrans !== 2'b00) $display("[TB] FAIL mis_htrans: got %h want 0", bus.htrans); else pass_count++;
        check_count++; if (bus.req_ready !== 1'b1) $display("[TB] FAIL mis_ready: got %b want 1", bus.req_ready); else pass_count++;
        step(); drive_req(1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'd0); bus.hrdata = 32'hFFFF_FFFF; #1;
        check_count++; if ({bus.rsp_valid, bus.rsp_misalign, bus.rsp_rdata} !== {2'b11, 32'd0}) $display("[TB] FAIL mis_word_rsp: got %b/%b/%h want 1/1/0", bus.rsp_valid, bus.rsp_misalign, bus.rsp_rdata); else pass_count++;
        check_count++; if (bus.htrans !== 2'b00) $display("[TB] FAIL mis_size3_htrans: got %h want 0", bus.htrans); else pass_count++;
        step(); drive_req(1'b0, 2'd1, 1'b0, 32'h0000_0001, 32'd0); #1;
        check_count++; if ({bus.rsp_valid, bus.rsp_misalign} !== 2'b11) $display("[TB] FAIL mis_size3_rsp: got %b want 11", {bus.rsp_valid, bus.rsp_misalign}); else pass_count++;
        check_count++; if (bus.htrans !== 2'b00) $display("[TB] FAIL mis_half_htrans: got %h want 0", bus.htrans); else pass_count++;
        step(); drop_req(); #1;
        check_count++; if ({bus.rsp_valid, bus.rsp_misalign} !== 2'b11) $display("[TB] FAIL mis_half_rsp: got %b want 11", {bus.rsp_valid, bus.rsp_misalign}); else pass_count++;
        step(); #1;
        check_count++; if (bus.rsp_misalign !== 1'b0) $display("[TB] FAIL mis_clear: got %b want 0", bus.rsp_misalign); else pass_count++;
    endtask

    task test_reset_mid_wait();
        step(); drive_req(1'b1, 2'd2, 1'b0, 32'h0000_0040, 32'hA5A5_A5A5); #1;
        step(); drive_req(1'b0, 2'd2, 1'b0, 32'h0000_0044, 32'd0); bus.hready = 1'b0; #1;
        check_count++; if (bus.hwdata !== 32'hA5A5_A5A5) $display("[TB] FAIL rst_pre_hwdata: got %h want a5a5a5a5", bus.hwdata); else pass_count++;
        #2 HRESETn = 1'b0;
        #1;
        check_count++; if (bus.hwdata !== 32'd0) $display("[TB] FAIL rst_hwdata: got %h want 0", bus.hwdata); else pass_count++;
        check_count++; if ({bus.req_ready, bus.rsp_valid, bus.htrans} !== 4'b0000) $display("[TB] FAIL rst_outputs: got %b want 0000", {bus.req_ready, bus.rsp_valid, bus.htrans}); else pass_count++;
        check_count++; if ({bus.rsp_error, bus.rsp_misalign, bus.rsp_rdata} !== 34'd0) $display("[TB] FAIL rst_rsp_fields: got %b/%b/%h want 0/0/0", bus.rsp_error, bus.rsp_misalign, bus.rsp_rdata); else pass_count++;
        step(); drop_req(); bus.hready = 1'b1; HRESETn = 1'b1; #1;
        check_count++; if (bus.rsp_valid !== 1'b0) $display("[TB] FAIL rst_no_rsp: got %b want 0", bus.rsp_valid); else pass_count++;
        step(); #1;
        check_count++; if (bus.rsp_valid !== 1'b0) $display("[TB] FAIL rst_no_rsp2: got %b want 0", bus.rsp_valid); else pass_count++;
    endtask

    initial begin
        $display("[TB] starting ahb_lsu_master bench");
        test_reset();
        test_word_load();
        test_byte_loads();
        test_half_store();
        test_back_to_back();
        test_error();
        test_misalign();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
